rv32i_mem_stage: RTL
====================

RV32I_MEM_STAGE -- requirements
Module: rv32i_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath/address width.
REQ-002 SHALL have parameter REGW, 5, register-index width.
REQ-003 SHALL have parameter MAX_WAIT, 15, cycles to wait for a dmem grant or response before an error is flagged.
REQ-004 Ports SHALL be, in order:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_ready  out  1  stage can accept an instruction.
- pc_in, iw_in, alu_in, rs2_in  in  XLEN  PC, instruction word, ALU result/address, store data.
- wb_reg_in  in  REGW  destination register.
- wb_en_in  in  1  writeback enable.
- flush  in  1  kill the in-flight instruction.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  XLEN  word-aligned address.
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_be  out  XLEN/8  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.
- wb_valid  out  1  output instruction valid.
- pc_out, iw_out, alu_out, wb_data_out  out  XLEN  PC, instruction word, ALU result, writeback data.
- wb_reg_out  out  REGW  destination register.
- wb_en_out  out  1  writeback enable.
- mem_err  out  1  one-cycle error pulse.

Function
REQ-005 Decode SHALL use iw_in[6:0]: 0000011 = load, 0100011 = store, any other value = pass-through.
REQ-006 Size SHALL come from iw_in[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other funct3 on a load or store SHALL be treated as misaligned.
REQ-007 FSM states SHALL be IDLE, REQ, WAIT, DRAIN.
REQ-008 ex_ready SHALL be 1 only in IDLE.
REQ-009 Pass-through: an accepted instruction SHALL appear on the outputs the next cycle with wb_valid=1 and wb_data_out=alu_in (latency 1).
REQ-010 Loads and stores SHALL move IDLE->REQ on acceptance, with the request fields registered.
REQ-011 In REQ, dmem_req SHALL stay 1 and its fields SHALL stay stable until dmem_gnt.
- Store + gnt: REQ->IDLE; the store retires the next cycle with wb_en_out=0.
- Load + gnt: REQ->WAIT.
REQ-012 In WAIT, dmem_rvalid SHALL retire the load the next cycle and return the FSM to IDLE.
REQ-013 gnt and rvalid in the same cycle SHALL be legal; the load then retires one cycle after the grant.
REQ-014 Load data SHALL be taken from byte lane alu_in[1:0], or half lane alu_in[1], then zero- or sign-extended to XLEN.
REQ-015 dmem_addr SHALL equal alu_in with bits [1:0] cleared.
REQ-016 dmem_be SHALL be:
- B: 0001 shifted left by alu_in[1:0].
- H: 0011 shifted left by 2*alu_in[1].
- W: 1111.
REQ-017 dmem_wdata SHALL be rs2_in replicated into the addressed lanes.
REQ-018 Misaligned access (H with alu_in[0]=1, or W with alu_in[1:0]!=0) SHALL:
- issue no request;
- retire next cycle with wb_en_out=0;
- pulse mem_err.
REQ-019 If the wait counter reaches MAX_WAIT in REQ or WAIT, the stage SHALL:
- pulse mem_err;
- retire with wb_en_out=0;
- go to IDLE, or to DRAIN if a load was granted.
REQ-020 flush SHALL act as follows:
- IDLE: drop the incoming instruction.
- REQ: deassert dmem_req the next cycle and return to IDLE.
- WAIT: go to DRAIN.
- In all cases no instruction is retired.
REQ-021 DRAIN SHALL discard one dmem_rvalid, then return to IDLE with ex_ready low throughout.
REQ-022 flush SHALL take priority over gnt and rvalid in the same cycle, except that a store already granted SHALL still count as performed.
REQ-023 wb_valid and mem_err SHALL be single-cycle pulses per retirement.
REQ-024 When wb_valid=0, wb_en_out SHALL be 0.

Reset
REQ-025 Asserting reset SHALL immediately force:
- state = IDLE;
- wb_valid, wb_en_out, dmem_req, dmem_we, mem_err = 0;
- all data outputs, dmem_be and the wait counter = 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no retirement.
REQ-027 After reset deasserts, ex_ready SHALL be 1 on the first clock edge.

Structure
REQ-028 Opcode constants, the funct3 size encodings and the FSM state enum SHALL live in shared package rv32i_pkg.
REQ-029 Lane steering and load extension SHALL be one combinational sub-module, rv32i_lsu_align.

Verification
REQ-030 ALU op: iw=0x00B50533, alu_in=0x1234 -> next cycle wb_valid=1, wb_data_out=0x1234, wb_en_out=1.
REQ-031 LB: alu_in=0x103, rdata=0x80FF_FFFF, gnt then rvalid after 2 cycles -> wb_data_out=0xFFFF_FF80, dmem_addr=0x100.
REQ-032 SH: alu_in=0x202, rs2=0xABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, wb_en_out=0.
REQ-033 LW at alu_in=0x6 -> no dmem_req, mem_err pulse, wb_en_out=0.
REQ-034 Load granted, then flush in WAIT, rvalid 3 cycles later -> no wb_valid, ex_ready low until the drained rvalid.
REQ-035 reset asserted with dmem_req=1 -> dmem_req=0 and state IDLE at once; no retirement.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-stage definitions.
// Opcodes, load/store size encodings and FSM states.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } mem_state_e;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Store lane steering, byte enables, misalignment
// detection and load extraction/extension.
module rv32i_lsu_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        st_f3,
  input  logic [1:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN/8-1:0] st_be,
  output logic [XLEN-1:0]   st_wdata,
  output logic              st_mis,
  input  logic [2:0]        ld_f3,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);

  localparam int BW = XLEN / 8;

  logic [XLEN-1:0] sh_b;
  logic [XLEN-1:0] sh_h;

  // Store side: enables, replicated data, alignment
  always_comb begin
    st_be    = '0;
    st_wdata = st_data;
    st_mis   = 1'b0;
    unique case (st_f3)
      F3_B, F3_BU: begin
        st_be    = {{(BW-1){1'b0}}, 1'b1} << st_off;
        st_wdata = {(XLEN/8){st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be    = {{(BW-2){1'b0}}, 2'b11}
                   << {st_off[1], 1'b0};
        st_wdata = {(XLEN/16){st_data[15:0]}};
        st_mis   = st_off[0];
      end
      F3_W: begin
        st_be  = '1;
        st_mis = |st_off;
      end
      default: st_mis = 1'b1;
    endcase
  end

  // Load side: pick the lane, then extend
  always_comb begin
    sh_b    = ld_rdata >> {ld_off, 3'b000};
    sh_h    = ld_rdata >> {ld_off[1], 4'b0000};
    ld_data = ld_rdata;
    unique case (ld_f3)
      F3_B:  ld_data = {{(XLEN-8){sh_b[7]}}, sh_b[7:0]};
      F3_BU: ld_data = {{(XLEN-8){1'b0}}, sh_b[7:0]};
      F3_H:  ld_data = {{(XLEN-16){sh_h[15]}}, sh_h[15:0]};
      F3_HU: ld_data = {{(XLEN-16){1'b0}}, sh_h[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: issues one dmem access at a
// time, retires pass-through ops with latency 1.
module rv32i_mem_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REGW     = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   iw_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic [REGW-1:0]   wb_reg_in,
  input  logic              wb_en_in,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   iw_out,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   wb_data_out,
  output logic [REGW-1:0]   wb_reg_out,
  output logic              wb_en_out,
  output logic              mem_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  mem_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, iw_q, iw_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic wen_q, wen_d, ld_q, ld_d;
  logic [XLEN-1:0] addr_q, addr_d, wdat_q, wdat_d;
  logic [XLEN/8-1:0] be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wbv_q, wbv_d, wbe_q, wbe_d, err_q, err_d;
  logic [XLEN-1:0] pco_q, pco_d, iwo_q, iwo_d;
  logic [XLEN-1:0] aluo_q, aluo_d, wbd_q, wbd_d;
  logic [REGW-1:0] rdo_q, rdo_d;

  logic is_ld, is_st, st_mis;
  logic [XLEN/8-1:0] st_be;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic ret, ret_in, ret_en, ret_err;
  logic [XLEN-1:0] ret_data;

  assign is_ld = (iw_in[6:0] == OP_LOAD);
  assign is_st = (iw_in[6:0] == OP_STORE);

  rv32i_lsu_align #(.XLEN(XLEN)) u_align (
    .st_f3    (iw_in[14:12]),
    .st_off   (alu_in[1:0]),
    .st_data  (rs2_in),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .st_mis   (st_mis),
    .ld_f3    (iw_q[14:12]),
    .ld_off   (alu_q[1:0]),
    .ld_rdata (dmem_rdata),
    .ld_data  (ld_data)
  );

  // State, held request and retirement registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      iw_q    <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      ld_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      wbv_q   <= 1'b0;
      wbe_q   <= 1'b0;
      err_q   <= 1'b0;
      pco_q   <= '0;
      iwo_q   <= '0;
      aluo_q  <= '0;
      wbd_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iw_q    <= iw_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      wbv_q   <= wbv_d;
      wbe_q   <= wbe_d;
      err_q   <= err_d;
      pco_q   <= pco_d;
      iwo_q   <= iwo_d;
      aluo_q  <= aluo_d;
      wbd_q   <= wbd_d;
      rdo_q   <= rdo_d;
    end
  end

  // Next state, request capture and retirement
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    iw_d     = iw_q;
    alu_d    = alu_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    ld_d     = ld_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    ret      = 1'b0;
    ret_in   = 1'b0;
    ret_en   = 1'b0;
    ret_err  = 1'b0;
    ret_data = alu_q;
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid && !flush) begin
          if (!(is_ld || is_st)) begin
            ret      = 1'b1;
            ret_in   = 1'b1;
            ret_en   = wb_en_in;
            ret_data = alu_in;
          end else if (st_mis) begin
            ret      = 1'b1;
            ret_in   = 1'b1;
            ret_err  = 1'b1;
            ret_data = alu_in;
          end else begin
            state_d = S_REQ;
            pc_d    = pc_in;
            iw_d    = iw_in;
            alu_d   = alu_in;
            rd_d    = wb_reg_in;
            wen_d   = wb_en_in;
            ld_d    = is_ld;
            addr_d  = {alu_in[XLEN-1:2], 2'b00};
            wdat_d  = st_wdata;
            be_d    = st_be;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          // A granted load still owes us a response
          if (dmem_gnt && ld_q && !dmem_rvalid)
            state_d = S_DRAIN;
          else
            state_d = S_IDLE;
        end else if (dmem_gnt) begin
          if (!ld_q) begin
            ret     = 1'b1;
            state_d = S_IDLE;
          end else if (dmem_rvalid) begin
            ret      = 1'b1;
            ret_en   = wen_q;
            ret_data = ld_data;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end else if (cnt_q == CMAX) begin
          ret     = 1'b1;
          ret_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = dmem_rvalid ? S_IDLE : S_DRAIN;
        end else if (dmem_rvalid) begin
          ret      = 1'b1;
          ret_en   = wen_q;
          ret_data = ld_data;
          state_d  = S_IDLE;
        end else if (cnt_q == CMAX) begin
          ret     = 1'b1;
          ret_err = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dmem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wbv_d  = ret;
    err_d  = ret_err;
    wbe_d  = ret & ret_en;
    pco_d  = pco_q;
    iwo_d  = iwo_q;
    aluo_d = aluo_q;
    wbd_d  = wbd_q;
    rdo_d  = rdo_q;
    if (ret) begin
      pco_d  = ret_in ? pc_in : pc_q;
      iwo_d  = ret_in ? iw_in : iw_q;
      aluo_d = ret_in ? alu_in : alu_q;
      rdo_d  = ret_in ? wb_reg_in : rd_q;
      wbd_d  = ret_data;
    end
  end

  // Handshake and memory request outputs
  always_comb begin
    ex_ready = (state_q == S_IDLE);
    dmem_req = (state_q == S_REQ);
    dmem_we  = (state_q == S_REQ) && !ld_q;
  end

  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdat_q;
  assign dmem_be     = be_q;
  assign wb_valid    = wbv_q;
  assign wb_en_out   = wbe_q;
  assign mem_err     = err_q;
  assign pc_out      = pco_q;
  assign iw_out      = iwo_q;
  assign alu_out     = aluo_q;
  assign wb_data_out = wbd_q;
  assign wb_reg_out  = rdo_q;

endmodule
